// File: rtl/store_buffer_if.sv
// Bundle of pipeline store/load, memory write and occupancy signals around the store buffer.
// master = pipeline/memory side driving requests and acks; slave = the store buffer itself.
interface store_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              stValid;
  logic [1:0]        stSize;
  logic [ADDR_W-1:0] stAddr;
  logic [DATA_W-1:0] stData;
  logic              stReady;
  logic              stAdes;

  logic              ldValid;
  logic [ADDR_W-1:0] ldAddr;
  logic              ldHazard;

  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [NB-1:0]     memWen;
  logic              memAck;

  logic [CNT_W-1:0]  sbCount;

  modport master (
    output stValid, stSize, stAddr, stData, ldValid, ldAddr, memAck,
    input  stReady, stAdes, ldHazard, memReq, memAddr, memWdata, memWen, sbCount
  );

  modport slave (
    input  stValid, stSize, stAddr, stData, ldValid, ldAddr, memAck,
    output stReady, stAdes, ldHazard, memReq, memAddr, memWdata, memWen, sbCount
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: decodes stores into byte-lane writes, queues them in a FIFO and drains them to memory.
// Define LOAD_HAZARD_EN to build the load-vs-pending-store alias detector; otherwise ldHazard is 0.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [OFF-1:0]    offset;
  logic [NB-1:0]     decWen;
  logic [DATA_W-1:0] decWdata;
  logic              misaligned;

  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [NB-1:0]     wenQ  [DEPTH];

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;

  logic stReady;
  logic stAdes;
  logic memReq;
  logic enq;
  logic pop;
  logic hazard;

  assign offset = sb.stAddr[OFF-1:0];

  // Narrow data is replicated across every lane so memory just applies the byte enables.
  always_comb begin
    decWen     = '0;
    decWdata   = '0;
    misaligned = 1'b0;
    case (sb.stSize)
      2'b00: begin
        decWen   = NB'(1) << offset;
        decWdata = {NB{sb.stData[7:0]}};
      end
      2'b01: begin
        decWen     = NB'(2'b11) << offset;
        decWdata   = {(NB/2){sb.stData[15:0]}};
        misaligned = offset[0];
      end
      2'b10: begin
        decWen     = NB'(4'hF) << offset;
        decWdata   = {(NB/4){sb.stData[31:0]}};
        misaligned = (offset[1:0] != 2'b00);
      end
      default: begin
        decWen     = '1;
        decWdata   = sb.stData;
        misaligned = (DATA_W != 64) || (offset != '0);
      end
    endcase
  end

  assign stAdes  = sb.stValid && misaligned;
  assign stReady = (count != CNT_W'(DEPTH));
  assign memReq  = (count != '0);
  assign enq     = sb.stValid && stReady && !stAdes;
  assign pop     = memReq && sb.memAck;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      addrQ[wrPtr] <= {sb.stAddr[ADDR_W-1:OFF], OFF'(0)};
      dataQ[wrPtr] <= decWdata;
      wenQ[wrPtr]  <= decWen;
    end
  end

`ifdef LOAD_HAZARD_EN
  logic [PTR_W-1:0] dist;
  logic             anyMatch;

  // An entry is live when its distance from the head is below the occupancy count.
  always_comb begin
    anyMatch = 1'b0;
    dist     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dist = PTR_W'(i) - rdPtr;
      if (({1'b0, dist} < count) &&
          (addrQ[i][ADDR_W-1:OFF] == sb.ldAddr[ADDR_W-1:OFF]))
        anyMatch = 1'b1;
    end
  end

  assign hazard = sb.ldValid && anyMatch;
`else
  logic unusedLd;
  assign unusedLd = ^{sb.ldValid, sb.ldAddr};
  assign hazard   = 1'b0;
`endif

  assign sb.stReady  = stReady;
  assign sb.stAdes   = stAdes;
  assign sb.ldHazard = hazard;
  assign sb.memReq   = memReq;
  assign sb.memAddr  = memReq ? addrQ[rdPtr] : '0;
  assign sb.memWdata = memReq ? dataQ[rdPtr] : '0;
  assign sb.memWen   = memReq ? wenQ[rdPtr]  : '0;
  assign sb.sbCount  = count;
endmodule
